// File: rtl/addsub_mem_if.sv
// Request/result/debug bundle between a control master and addsub_mem_unit.
// The overflow signal exists only when ADDSUB_OVF_EN is defined.
interface addsub_mem_if #(
   parameter int WORDSIZE = 64,
   parameter int ADDR_W   = 5
);
   logic                start;
   logic [WORDSIZE-1:0] num1;
   logic [WORDSIZE-1:0] num2;
   logic                operation;
   logic                busy;
   logic                done;
   logic [WORDSIZE-1:0] result;
   logic [ADDR_W-1:0]   dbg_addr;
   logic [WORDSIZE-1:0] dbg_data;
`ifdef ADDSUB_OVF_EN
   logic                overflow;
`endif

   modport master (
      output start, num1, num2, operation, dbg_addr,
`ifdef ADDSUB_OVF_EN
      input  overflow,
`endif
      input  busy, done, result, dbg_data
   );

   modport slave (
      input  start, num1, num2, operation, dbg_addr,
`ifdef ADDSUB_OVF_EN
      output overflow,
`endif
      output busy, done, result, dbg_data
   );
endinterface

// File: rtl/addsub_mem_unit.sv
// Sequenced add/subtract unit staging operands and result through a small register-array memory.
// Optional signed overflow flag enabled by defining ADDSUB_OVF_EN.
module addsub_mem_unit #(
   parameter int WORDSIZE = 64,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   addsub_mem_if.slave     bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR_A = 3'd1,
      WR_B = 3'd2,
      RD_A = 3'd3,
      RD_B = 3'd4,
      EXEC = 3'd5,
      WB   = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic [WORDSIZE-1:0] a_q, b_q;
   logic                op_q;
   logic [WORDSIZE-1:0] opa_q, opb_q;
   logic [WORDSIZE-1:0] result_q;
   logic [WORDSIZE-1:0] mem_q [DEPTH];

   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [WORDSIZE-1:0] mem_wdata;

   // Subtraction reuses the adder: opa + ~opb + 1.
   logic [WORDSIZE-1:0] b_eff;
   logic [WORDSIZE-1:0] sum;
   assign b_eff = op_q ? ~opb_q : opb_q;
   assign sum   = opa_q + b_eff + {{(WORDSIZE-1){1'b0}}, op_q};

   always_comb begin
      state_d   = state_q;
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = a_q;
      case (state_q)
         IDLE: if (bus.start) state_d = WR_A;
         WR_A: begin
            mem_we    = 1'b1;
            mem_waddr = ADDR_W'(0);
            mem_wdata = a_q;
            state_d   = WR_B;
         end
         WR_B: begin
            mem_we    = 1'b1;
            mem_waddr = ADDR_W'(1);
            mem_wdata = b_q;
            state_d   = RD_A;
         end
         RD_A: state_d = RD_B;
         RD_B: state_d = EXEC;
         EXEC: state_d = WB;
         WB: begin
            mem_we    = 1'b1;
            mem_waddr = ADDR_W'(2);
            mem_wdata = result_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= 1'b0;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && bus.start) begin
            a_q  <= bus.num1;
            b_q  <= bus.num2;
            op_q <= bus.operation;
         end
         if (state_q == RD_A) opa_q <= mem_q[0];
         if (state_q == RD_B) opb_q <= mem_q[1];
         if (state_q == EXEC) result_q <= sum;
      end
   end

   // Storage is deliberately left out of reset so completed writes survive an abort.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   generate
      if (DEPTH == (1 << ADDR_W)) begin : g_dbg_full
         assign bus.dbg_data = mem_q[bus.dbg_addr];
      end else begin : g_dbg_partial
         localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];
         assign bus.dbg_data = ({1'b0, bus.dbg_addr} < DEPTH_W) ? mem_q[bus.dbg_addr] : '0;
      end
   endgenerate

   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = (state_q == WB);
   assign bus.result = result_q;

`ifdef ADDSUB_OVF_EN
   logic ovf_q;
   // Effective operands share a sign but the sum's sign differs: covers both add and subtract.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (state_q == EXEC) begin
         ovf_q <= (opa_q[WORDSIZE-1] == b_eff[WORDSIZE-1]) &&
                  (sum[WORDSIZE-1] != opa_q[WORDSIZE-1]);
      end
   end
   assign bus.overflow = ovf_q;
`endif

endmodule

// File: tb/tb_addsub_mem_unit.sv
// Randomized self-checking bench for addsub_mem_unit against a plain-arithmetic reference.
module tb_addsub_mem_unit;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [63:0] mem_m [3];

   addsub_mem_if #(.WORDSIZE(64), .ADDR_W(5)) bus ();

   addsub_mem_unit #(.WORDSIZE(64), .DEPTH(32), .ADDR_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_result(input logic [63:0] a, input logic [63:0] b, input bit op);
      return op ? (a - b) : (a + b);
   endfunction

   function automatic bit ref_ovf(input logic [63:0] a, input logic [63:0] b, input bit op);
      logic [64:0] s;
      s = op ? ({a[63], a} - {b[63], b}) : ({a[63], a} + {b[63], b});
      return s[64] ^ s[63];
   endfunction

   task automatic check_mem(input string tag);
      for (int i = 0; i < 3; i++) begin
         bus.dbg_addr = 5'(i);
         #1;
         check($sformatf("%s_mem%0d", tag, i), bus.dbg_data, mem_m[i]);
      end
   endtask

   // Called at a falling edge; returns just after the falling edge following the write-back.
   task automatic do_op(input logic [63:0] a, input logic [63:0] b, input bit op);
      int lat;
      logic [63:0] exp;
      bus.num1      = a;
      bus.num2      = b;
      bus.operation = op;
      bus.start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start     = 1'b0;
      bus.num1      = {$urandom, $urandom};
      bus.num2      = {$urandom, $urandom};
      bus.operation = ~op;
      check("busy_run", 64'(bus.busy), 64'd1);
      lat = 0;
      while (!bus.done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 64'(lat), 64'd5);
      exp = ref_result(a, b, op);
      check("result", bus.result, exp);
`ifdef ADDSUB_OVF_EN
      check("overflow", 64'(bus.overflow), 64'(ref_ovf(a, b, op)));
`endif
      @(negedge clk);
      check("done_clear", 64'(bus.done), 64'd0);
      check("busy_clear", 64'(bus.busy), 64'd0);
      check("result_hold", bus.result, exp);
      mem_m[0] = a;
      mem_m[1] = b;
      mem_m[2] = exp;
      check_mem("op");
      $display("op %h %s %h -> %h (latency %0d)", a, op ? "-" : "+", b, bus.result, lat);
   endtask

   initial begin
      int ndone;
      logic [63:0] seen;
      logic [63:0] ra, rb;
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.num1 = '0;
      bus.num2 = '0;
      bus.operation = 1'b0;
      bus.dbg_addr = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_result", bus.result, 64'd0);
`ifdef ADDSUB_OVF_EN
      check("rst_ovf", 64'(bus.overflow), 64'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      do_op(64'd5, 64'd3, 1'b0);
      do_op(64'd3, 64'd5, 1'b1);
      do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      do_op(64'h8000_0000_0000_0000, 64'd1, 1'b1);
      do_op(64'd4, 64'd4, 1'b0);

      // Second start pulse while busy must be dropped.
      @(negedge clk);
      bus.num1 = 64'd7; bus.num2 = 64'd2; bus.operation = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.num1 = 64'd100; bus.num2 = 64'd1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      ndone = 0;
      seen = '0;
      for (int i = 0; i < 10; i++) begin
         if (bus.done) begin
            ndone++;
            seen = bus.result;
         end
         @(negedge clk);
      end
      check("busy_start_dones", 64'(ndone), 64'd1);
      check("busy_start_result", seen, 64'd9);
      mem_m[0] = 64'd7; mem_m[1] = 64'd2; mem_m[2] = 64'd9;
      check_mem("ignored");
      $display("op 7 + 2 with ignored restart -> %0d, dones %0d", seen, ndone);
      @(negedge clk);
      do_op(64'd100, 64'd1, 1'b1);

      // Abort after both operand writes have landed.
      @(negedge clk);
      bus.num1 = 64'd10; bus.num2 = 64'd20; bus.operation = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_done", 64'(bus.done), 64'd0);
      check("abort_result", bus.result, 64'd0);
`ifdef ADDSUB_OVF_EN
      check("abort_ovf", 64'(bus.overflow), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      mem_m[0] = 64'd10; mem_m[1] = 64'd20;
      check_mem("abort");
      $display("abort 10 + 20 mid-operation, result %0d", bus.result);
      @(negedge clk);
      check("abort_no_done", 64'(bus.done), 64'd0);
      do_op(64'd10, 64'd20, 1'b0);

      for (int n = 0; n < 20; n++) begin
         case ($urandom_range(0, 3))
            0: ra = 64'h8000_0000_0000_0000;
            1: ra = 64'h7FFF_FFFF_FFFF_FFFF;
            default: ra = {$urandom, $urandom};
         endcase
         case ($urandom_range(0, 3))
            0: rb = 64'hFFFF_FFFF_FFFF_FFFF;
            1: rb = 64'd1;
            default: rb = {$urandom, $urandom};
         endcase
         do_op(ra, rb, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
